// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC phase path: turn size, quadrant width,
// CORDIC pipeline latency and the Phase word field layout.
package cordic_pkg;
   localparam int ACC_W          = 25;
   localparam int FULL_TURN      = 360 << 16;
   localparam int QUARTER_DEG    = 90;
   localparam int CORDIC_LAT_DEF = 18;
   localparam int QUAD_LSB       = 16;
   localparam int DEG_MSB        = 15;
endpackage

// File: rtl/cordic_phase_quadrant.sv
// Folds an integer angle 0..359 into the CORDIC Phase word
// {14'b0, quadrant, degrees-within-quadrant}.
module cordic_phase_quadrant
   import cordic_pkg::*;
(
   input  logic [8:0]  deg_int,
   output logic [31:0] phase
);
   logic [1:0] quad;
   logic [8:0] deg;

   always_comb begin
      quad  = 2'd0;
      deg   = deg_int;
      phase = '0;
      if (deg_int >= 9'(3 * QUARTER_DEG)) begin
         quad = 2'd3;
         deg  = deg_int - 9'(3 * QUARTER_DEG);
      end else if (deg_int >= 9'(2 * QUARTER_DEG)) begin
         quad = 2'd2;
         deg  = deg_int - 9'(2 * QUARTER_DEG);
      end else if (deg_int >= 9'(QUARTER_DEG)) begin
         quad = 2'd1;
         deg  = deg_int - 9'(QUARTER_DEG);
      end
      phase[QUAD_LSB+1:QUAD_LSB] = quad;
      phase[DEG_MSB:0]           = 16'(deg);
   end
endmodule

// File: rtl/cordic_phase_gen.sv
// Fractional-degree NCO feeding the pipelined CORDIC: wraps modulo 360 degrees,
// emits quadrant/degree Phase words and a valid aligned to the CORDIC output.
module cordic_phase_gen
   import cordic_pkg::*;
#(
   parameter int FRAC_W     = 16,
   parameter int CORDIC_LAT = CORDIC_LAT_DEF
) (
   input  logic        CLK_50M,
   input  logic        RST_N,
   input  logic        Enable,
   input  logic        Load,
   input  logic [31:0] Step,
   input  logic [31:0] Init_Phase,
   output logic [31:0] Phase,
   output logic        Phase_Valid,
   output logic        Wrap,
   output logic        Cordic_Valid,
   output logic        Cfg_Err
);
   localparam int              AW      = FRAC_W + 9;
   localparam logic [31:0]     FULL_32 = 32'(360) << FRAC_W;
   localparam logic [AW-1:0]   FULL_A  = AW'(360) << FRAC_W;

   // Out-of-range configuration words collapse to zero rather than corrupting acc.
   function automatic logic [AW-1:0] legal_or_zero(input logic [31:0] v);
      return (v < FULL_32) ? v[AW-1:0] : '0;
   endfunction

   logic [AW-1:0]         acc_p0;
   logic [AW-1:0]         step_r;
   logic [AW:0]           sum_p0;
   logic [AW-1:0]         sum_wrap_p0;
   logic [31:0]           phase_conv_p0;
   logic [CORDIC_LAT-1:0] vld_dly;

   assign sum_p0      = {1'b0, acc_p0} + {1'b0, step_r};
   assign sum_wrap_p0 = sum_p0[AW-1:0] - FULL_A;

   cordic_phase_quadrant u_quad (
      .deg_int (acc_p0[AW-1:FRAC_W]),
      .phase   (phase_conv_p0)
   );

   // Stage p0 -> outputs: Phase carries the pre-update accumulator value
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         acc_p0      <= '0;
         step_r      <= '0;
         Phase       <= '0;
         Phase_Valid <= 1'b0;
         Wrap        <= 1'b0;
         Cfg_Err     <= 1'b0;
      end else if (Load) begin
         step_r      <= legal_or_zero(Step);
         acc_p0      <= legal_or_zero(Init_Phase);
         Cfg_Err     <= (Step >= FULL_32) | (Init_Phase >= FULL_32);
         Phase_Valid <= 1'b0;
         Wrap        <= 1'b0;
      end else if (Enable) begin
         Phase       <= phase_conv_p0;
         Phase_Valid <= 1'b1;
         if (sum_p0 >= {1'b0, FULL_A}) begin
            acc_p0 <= sum_wrap_p0;
            Wrap   <= 1'b1;
         end else begin
            acc_p0 <= sum_p0[AW-1:0];
            Wrap   <= 1'b0;
         end
      end else begin
         Phase_Valid <= 1'b0;
         Wrap        <= 1'b0;
      end
   end

   // Valid delay matching the CORDIC pipeline; runs free of Enable
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) vld_dly <= '0;
      else        vld_dly <= {vld_dly[CORDIC_LAT-2:0], Phase_Valid};
   end

   assign Cordic_Valid = vld_dly[CORDIC_LAT-1];
endmodule

// File: tb/tb_cordic_phase_gen.sv
// Bench for cordic_phase_gen: turn-level reference model compared every cycle,
// plus directed vectors with hand-computed Phase words.
module tb_cordic_phase_gen;
   localparam longint FULL = 360 * 65536;

   logic        CLK_50M = 1'b0;
   logic        RST_N = 1'b0;
   logic        Enable = 1'b0;
   logic        Load = 1'b0;
   logic [31:0] Step = '0;
   logic [31:0] Init_Phase = '0;
   logic [31:0] Phase;
   logic        Phase_Valid, Wrap, Cordic_Valid, Cfg_Err;

   cordic_phase_gen dut (
      .CLK_50M      (CLK_50M),
      .RST_N        (RST_N),
      .Enable       (Enable),
      .Load         (Load),
      .Step         (Step),
      .Init_Phase   (Init_Phase),
      .Phase        (Phase),
      .Phase_Valid  (Phase_Valid),
      .Wrap         (Wrap),
      .Cordic_Valid (Cordic_Valid),
      .Cfg_Err      (Cfg_Err)
   );

   always #10 CLK_50M = ~CLK_50M;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: angle kept as an integer in 1/65536 degree, folded by division.
   longint      m_acc, m_step;
   logic [31:0] m_phase;
   bit          m_pv, m_wrap, m_err, m_cv;
   bit          hist[$];

   function automatic logic [31:0] conv(input longint a);
      longint d = a / 65536;
      return 32'((d / 90) * 65536 + (d % 90));
   endfunction

   always @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         m_acc = 0; m_step = 0; m_phase = '0;
         m_pv = 0; m_wrap = 0; m_err = 0; m_cv = 0;
         hist.delete();
         repeat (17) hist.push_back(1'b0);
      end else begin
         hist.push_back(m_pv);
         m_cv = hist.pop_front();
         if (Load) begin
            m_step = (Step < FULL) ? longint'(Step) : 0;
            m_acc  = (Init_Phase < FULL) ? longint'(Init_Phase) : 0;
            m_err  = (Step >= FULL) || (Init_Phase >= FULL);
            m_pv   = 0;
            m_wrap = 0;
         end else if (Enable) begin
            m_phase = conv(m_acc);
            m_pv    = 1;
            m_acc   = m_acc + m_step;
            m_wrap  = (m_acc >= FULL);
            m_acc   = m_acc % FULL;
         end else begin
            m_pv   = 0;
            m_wrap = 0;
         end
      end
   end

   always @(negedge CLK_50M) begin
      chk("phase", Phase, m_phase);
      chk("phase_valid", 32'(Phase_Valid), 32'(m_pv));
      chk("wrap", 32'(Wrap), 32'(m_wrap));
      chk("cordic_valid", 32'(Cordic_Valid), 32'(m_cv));
      chk("cfg_err", 32'(Cfg_Err), 32'(m_err));
   end

   task automatic cyc();
      @(posedge CLK_50M);
      #2;
   endtask

   task automatic load(input logic [31:0] s, input logic [31:0] i);
      Step = s; Init_Phase = i; Load = 1'b1; Enable = 1'b0;
      cyc();
      Load = 1'b0;
   endtask

   logic [32:0] cap[$];
   logic [31:0] exp4[4];
   bit          pat[4];
   logic [31:0] held;
   int          wraps, wpos;

   initial begin
      repeat (3) cyc();
      chk("rst_phase", Phase, 32'h0);
      chk("rst_pv", 32'(Phase_Valid), 32'h0);
      chk("rst_cv", 32'(Cordic_Valid), 32'h0);
      chk("rst_err", 32'(Cfg_Err), 32'h0);
      RST_N = 1'b1;
      cyc();

      // 5-degree steps over a full turn and back to zero
      load(32'h0005_0000, 32'h0);
      Enable = 1'b1;
      for (int i = 0; i < 80; i++) begin
         cyc();
         if (Phase_Valid) cap.push_back({Wrap, Phase});
      end
      Enable = 1'b0;
      chk("t1_count", 32'(cap.size()), 32'd80);
      if (cap.size() == 80) begin
         chk("t1_s0", cap[0][31:0], 32'h0000_0000);
         chk("t1_s1", cap[1][31:0], 32'h0000_0005);
         chk("t1_s17", cap[17][31:0], 32'h0000_0055);
         chk("t1_s18", cap[18][31:0], 32'h0001_0000);
         chk("t1_s36", cap[36][31:0], 32'h0002_0000);
         chk("t1_s71", cap[71][31:0], 32'h0003_0055);
         chk("t1_s72", cap[72][31:0], 32'h0000_0000);
      end
      wraps = 0; wpos = -1;
      foreach (cap[k]) if (cap[k][32]) begin wraps++; wpos = k; end
      chk("t1_wraps", 32'(wraps), 32'd1);
      chk("t1_wrap_pos", 32'(wpos), 32'd71);
      cyc();

      // half-degree steps across the 90 degree boundary, fraction truncated
      load(32'h0000_8000, 32'h0059_0000);
      exp4 = '{32'h0000_0059, 32'h0000_0059, 32'h0001_0000, 32'h0001_0000};
      Enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t2_phase", Phase, exp4[i]);
      end
      Enable = 1'b0;
      cyc();

      // illegal Step then illegal Init, each cleared by a legal load
      load(32'h0168_0000, 32'h002D_0000);
      chk("t3_err_step", 32'(Cfg_Err), 32'h1);
      Enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t3_const_phase", Phase, 32'h0000_002D);
         chk("t3_no_wrap", 32'(Wrap), 32'h0);
      end
      Enable = 1'b0;
      load(32'h0001_0000, 32'h0);
      chk("t3_err_clear", 32'(Cfg_Err), 32'h0);
      load(32'h0001_0000, 32'h0168_0000);
      chk("t3_err_init", 32'(Cfg_Err), 32'h1);
      Enable = 1'b1;
      cyc();
      chk("t3_init_zeroed", Phase, 32'h0);
      Enable = 1'b0;
      load(32'h0001_0000, 32'h0);
      chk("t3_err_clear2", 32'(Cfg_Err), 32'h0);

      // Enable pattern 1,1,0,1 and its Cordic_Valid image 18 cycles on
      repeat (20) cyc();
      pat = '{1'b1, 1'b1, 1'b0, 1'b1};
      held = '0;
      for (int i = 0; i < 4; i++) begin
         Enable = pat[i];
         cyc();
         chk("t4_pv", 32'(Phase_Valid), 32'(pat[i]));
         if (i == 1) held = Phase;
         if (i == 2) chk("t4_hold", Phase, held);
      end
      Enable = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         cyc();
         chk("t4_cv", 32'(Cordic_Valid), 32'((j == 15) || (j == 16) || (j == 18)));
      end

      // Load wins over Enable; following Enable emits Init_Phase
      Step = 32'h0001_0000; Init_Phase = 32'h00B4_0000;
      Load = 1'b1; Enable = 1'b1;
      cyc();
      chk("t5_no_sample", 32'(Phase_Valid), 32'h0);
      Load = 1'b0;
      cyc();
      chk("t5_first", Phase, 32'h0002_0000);
      chk("t5_first_pv", 32'(Phase_Valid), 32'h1);

      // reset with samples in flight
      repeat (11) cyc();
      RST_N = 1'b0;
      #1;
      chk("t6_phase", Phase, 32'h0);
      chk("t6_pv", 32'(Phase_Valid), 32'h0);
      chk("t6_cv", 32'(Cordic_Valid), 32'h0);
      Enable = 1'b0;
      cyc();
      RST_N = 1'b1;
      for (int j = 0; j < 25; j++) begin
         cyc();
         chk("t6_no_stale_cv", 32'(Cordic_Valid), 32'h0);
      end
      Enable = 1'b1;
      cyc();
      Enable = 1'b0;
      for (int j = 1; j <= 19; j++) begin
         cyc();
         chk("t6_cv_after", 32'(Cordic_Valid), 32'(j == 18));
      end

      repeat (2) cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
